// File: rtl/icache_pkg.sv
// Shared widths, FSM encodings and address-split helpers for the direct-mapped icache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_pkg;

   localparam int ADDR_W   = 32;
   localparam int LINE_W   = 128;
   localparam int OFFSET_W = 4;
   localparam int LADDR_W  = ADDR_W - OFFSET_W;
   localparam int CNT_W    = 16;

   typedef logic [LINE_W-1:0]  line_t;
   typedef logic [LADDR_W-1:0] laddr_t;

   // FSM encodings: IDLE accepts, HIT_RSP presents a hit, MISS_WAIT counts down the refill
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_HIT_RSP   = 2'd1;
   localparam logic [1:0] S_MISS_WAIT = 2'd2;

   // Line address: the fetch address with the byte-in-line offset dropped
   function automatic laddr_t line_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W];
   endfunction

   // Cache index: low idx_w bits of the line address (caller truncates to its IDX_W)
   function automatic laddr_t index_of(input laddr_t la, input int idx_w);
      return la & ((LADDR_W'(1) << idx_w) - LADDR_W'(1));
   endfunction

   // Cache tag: line address bits above the index (caller truncates to its TAG_W)
   function automatic laddr_t tag_of(input laddr_t la, input int idx_w);
      return la >> idx_w;
   endfunction

   // Saturating increment for the perf counters
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch request/response bundle between the instruction fetch queue and the icache.
// Latency: n/a (wires only).
// Backpressure: none; requester holds pc_in/rd_en until Dout_valid or abort.
interface icache_dm_if;
   import icache_pkg::*;

   logic [ADDR_W-1:0] pc_in;
   logic              rd_en;
   logic              abort;
   logic [LINE_W-1:0] Dout;
   logic              Dout_valid;

   modport master (
      output pc_in, rd_en, abort,
      input  Dout, Dout_valid
   );

   modport slave (
      input  pc_in, rd_en, abort,
      output Dout, Dout_valid
   );

endinterface

// File: rtl/icache_backing_mem.sv
// Backing store behind the icache: MEM_DEPTH lines of 128 bits, zero-initialised at start.
// Latency: combinational read.
// Backpressure: none; always ready.
module icache_backing_mem
   import icache_pkg::*;
#(
   parameter int    MEM_DEPTH = 256,
   parameter string MEM_FILE  = "",
   parameter int    MEM_AW    = $clog2(MEM_DEPTH)
) (
   input  logic [MEM_AW-1:0] addr,
   output line_t             rdata
);

   line_t mem [MEM_DEPTH];

   // Start from an all-zero store
   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         mem[i] = '0;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache answering IFQ fetches with one 128-bit line per request.
// Latency: hit valid 1 cycle after accept; miss valid MISS_LATENCY+1 cycles after accept.
// Backpressure: one outstanding request; requests ignored outside IDLE, abort cancels.
module icache_dm
   import icache_pkg::*;
#(
   parameter int    NUM_LINES    = 16,
   parameter int    MEM_DEPTH    = 256,
   parameter int    MISS_LATENCY = 4,
   parameter string MEM_FILE     = ""
) (
   input  logic             clk,
   input  logic             rst,
   icache_dm_if.slave       bus,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam int TAG_W  = LADDR_W - IDX_W;
   localparam int WAIT_W = $clog2(MISS_LATENCY) + 1;

   logic [1:0]           state_q,    state_d;
   laddr_t               pc_q,       pc_d;
   line_t                dout_q,     dout_d;
   logic                 mvld_q,     mvld_d;
   logic [WAIT_W-1:0]    wait_q,     wait_d;
   logic [CNT_W-1:0]     hit_cnt_q,  hit_cnt_d;
   logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
   logic [NUM_LINES-1:0] valid_q,    valid_d;

   // Tag and data storage carry no reset; the valid bits alone decide hits
   logic [TAG_W-1:0] tag_mem  [NUM_LINES];
   line_t            data_mem [NUM_LINES];

   laddr_t           req_line;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             lookup_hit;
   logic             fill_en;
   line_t            mem_rdata;

   // Lookup uses the live request address; refill uses the address latched at accept
   assign req_line   = line_of(bus.pc_in);
   assign req_idx    = IDX_W'(index_of(req_line, IDX_W));
   assign req_tag    = TAG_W'(tag_of(req_line, IDX_W));
   assign fill_idx   = IDX_W'(index_of(pc_q, IDX_W));
   assign fill_tag   = TAG_W'(tag_of(pc_q, IDX_W));
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   // Backing line index wraps: only the low MEM_AW bits of the line address select it
   icache_backing_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .MEM_FILE  (MEM_FILE),
      .MEM_AW    (MEM_AW)
   ) u_mem (
      .addr  (pc_q[MEM_AW-1:0]),
      .rdata (mem_rdata)
   );

   // Next-state logic: accept in IDLE, present hits for one cycle, count down refills
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      dout_d     = dout_q;
      mvld_d     = 1'b0;
      wait_d     = wait_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      valid_d    = valid_q;
      fill_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.rd_en && !bus.abort) begin
               pc_d = req_line;
               if (lookup_hit) begin
                  dout_d    = data_mem[req_idx];
                  hit_cnt_d = sat_inc(hit_cnt_q);
                  state_d   = S_HIT_RSP;
               end else begin
                  miss_cnt_d = sat_inc(miss_cnt_q);
                  wait_d     = WAIT_W'(MISS_LATENCY - 1);
                  state_d    = S_MISS_WAIT;
               end
            end
         end
         S_HIT_RSP: begin
            state_d = S_IDLE;
         end
         S_MISS_WAIT: begin
            // Abort wins even on the completing edge, so a redirected fetch never pollutes the cache
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (wait_q == '0) begin
               fill_en           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               dout_d            = mem_rdata;
               mvld_d            = 1'b1;
               state_d           = S_IDLE;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control, output and counter state with asynchronous reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         dout_q     <= '0;
         mvld_q     <= 1'b0;
         wait_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dout_q     <= dout_d;
         mvld_q     <= mvld_d;
         wait_q     <= wait_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         valid_q    <= valid_d;
      end
   end

   // Refill writes the indexed line unconditionally: direct-mapped replacement
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_rdata;
      end
   end

   // A hit response can still be squashed by abort in its own cycle; miss responses are registered
   assign bus.Dout       = dout_q;
   assign bus.Dout_valid = ((state_q == S_HIT_RSP) && !bus.abort) || mvld_q;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed table, hand-written corner sequences, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_icache_dm;
   import icache_pkg::*;

   localparam int ML = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   icache_dm_if bus();

   icache_dm #(
      .NUM_LINES    (16),
      .MEM_DEPTH    (256),
      .MISS_LATENCY (ML),
      .MEM_FILE     ("")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: which line address each cache slot holds, plus counters and last line
   bit          m_vld [16];
   int unsigned m_key [16];
   int unsigned m_hits;
   int unsigned m_miss;
   line_t       m_dout;

   typedef struct {
      logic [31:0] addr;
      int          abort_k;
      int          exp_k;
      line_t       exp_dat;
      logic [15:0] exp_hit;
      logic [15:0] exp_miss;
   } vec_t;

   vec_t tbl [8];

   function automatic line_t mem_line(input int unsigned key);
      logic [31:0] w;
      w = key % 256;
      return {w, w, w, w};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_vld[i] = 1'b0;
         m_key[i] = 0;
      end
      m_hits = 0;
      m_miss = 0;
      m_dout = '0;
   endtask

   // Predict the response cycle (0 = none) and the line for one request, and update the model
   task automatic model_step(input logic [31:0] addr, input int abort_k,
                             output int exp_k, output line_t exp_dat);
      int unsigned key;
      int          idx;
      key     = addr >> 4;
      idx     = key % 16;
      exp_dat = mem_line(key);
      if (m_vld[idx] && m_key[idx] == key) begin
         if (m_hits < 65535) m_hits++;
         m_dout = exp_dat;
         exp_k  = (abort_k == 1) ? 0 : 1;
      end else begin
         if (m_miss < 65535) m_miss++;
         if (abort_k >= 1 && abort_k <= ML) begin
            exp_k = 0;
         end else begin
            exp_k      = ML + 1;
            m_vld[idx] = 1'b1;
            m_key[idx] = key;
            m_dout     = exp_dat;
         end
      end
   endtask

   // Issue one request; vld_k is the cycle after accept in which Dout_valid was seen (0 = never)
   task automatic fetch(input logic [31:0] addr, input int abort_k,
                        output int vld_k, output line_t dat);
      bit aborted;
      aborted = 1'b0;
      vld_k   = 0;
      dat     = '0;
      @(negedge clk);
      bus.pc_in = addr;
      bus.rd_en = 1'b1;
      bus.abort = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.abort = (k == abort_k);
         #1;
         if (bus.Dout_valid) begin
            vld_k = k;
            dat   = bus.Dout;
            break;
         end
         if (bus.abort) begin
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         @(posedge clk);
         #1;
      end
      bus.rd_en = 1'b0;
      bus.abort = 1'b0;
      if (aborted) begin
         repeat (ML + 2) begin
            @(negedge clk);
            #1;
            if (bus.Dout_valid) vld_k = -1;
         end
      end
   endtask

   task automatic run_check(input string name, input logic [31:0] addr, input int abort_k);
      int    exp_k;
      int    got_k;
      line_t exp_dat;
      line_t got_dat;
      model_step(addr, abort_k, exp_k, exp_dat);
      fetch(addr, abort_k, got_k, got_dat);
      chk({name, "_cycle"}, got_k, exp_k);
      if (exp_k > 0) chk({name, "_dout"}, got_dat, exp_dat);
      chk({name, "_hits"}, hit_count, m_hits);
      chk({name, "_miss"}, miss_count, m_miss);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    got_k;
      line_t got_dat;
      int    exp_k;
      line_t exp_dat;
      logic [31:0] a;
      int          ab;

      tbl[0] = '{32'h0000_0040, 0, 5, {4{32'h4}},  16'd0, 16'd1};
      tbl[1] = '{32'h0000_004C, 0, 1, {4{32'h4}},  16'd1, 16'd1};
      tbl[2] = '{32'h0000_0000, 0, 5, {4{32'h0}},  16'd1, 16'd2};
      tbl[3] = '{32'h0000_0100, 0, 5, {4{32'h10}}, 16'd1, 16'd3};
      tbl[4] = '{32'h0000_0000, 0, 5, {4{32'h0}},  16'd1, 16'd4};
      tbl[5] = '{32'h0000_0080, 2, 0, {4{32'h8}},  16'd1, 16'd5};
      tbl[6] = '{32'h0000_0080, 0, 5, {4{32'h8}},  16'd1, 16'd6};
      tbl[7] = '{32'h0000_0040, 1, 0, {4{32'h4}},  16'd2, 16'd6};

      bus.pc_in = '0;
      bus.rd_en = 1'b0;
      bus.abort = 1'b0;
      #1;
      for (int k = 0; k < 256; k++) begin
         dut.u_mem.mem[k] = mem_line(k);
      end

      // Held in reset: activity on the request side must not disturb the outputs
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.pc_in = $urandom;
         bus.rd_en = i[0];
         #1;
         chk("rst_dout", bus.Dout, '0);
         chk("rst_dvld", bus.Dout_valid, 1'b0);
         chk("rst_hits", hit_count, 16'd0);
         chk("rst_miss", miss_count, 16'd0);
      end
      @(negedge clk);
      bus.rd_en = 1'b0;
      rst       = 1'b1;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("idle_dvld", bus.Dout_valid, 1'b0);
      end
      chk("idle_hits", hit_count, 16'd0);
      chk("idle_miss", miss_count, 16'd0);

      // Directed table: miss/hit timing, index conflicts, aborts
      for (int i = 0; i < 8; i++) begin
         model_step(tbl[i].addr, tbl[i].abort_k, exp_k, exp_dat);
         fetch(tbl[i].addr, tbl[i].abort_k, got_k, got_dat);
         chk($sformatf("tbl%0d_cycle", i), got_k, tbl[i].exp_k);
         if (tbl[i].exp_k > 0) chk($sformatf("tbl%0d_dout", i), got_dat, tbl[i].exp_dat);
         chk($sformatf("tbl%0d_hits", i), hit_count, tbl[i].exp_hit);
         chk($sformatf("tbl%0d_miss", i), miss_count, tbl[i].exp_miss);
      end

      // Dout keeps the last line loaded (the aborted hit still loaded it)
      chk("dout_hold", bus.Dout, {4{32'h4}});

      // rd_en with abort in IDLE is never accepted
      @(negedge clk);
      bus.pc_in = 32'h40;
      bus.rd_en = 1'b1;
      bus.abort = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("idle_abort_dvld", bus.Dout_valid, 1'b0);
      end
      bus.rd_en = 1'b0;
      bus.abort = 1'b0;
      chk("idle_abort_hits", hit_count, 16'd2);
      chk("idle_abort_miss", miss_count, 16'd6);

      // Random traffic: few indices and several upper-bit aliases to mix hits, conflicts and wraps
      repeat (120) begin
         a  = ($urandom_range(0, 3) << 28) | ($urandom_range(0, 47) << 4) | $urandom_range(0, 15);
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
         run_check("rnd", a, ab);
      end

      // Reset in the middle of a refill
      run_check("pre_rst", 32'h40, 0);
      @(negedge clk);
      bus.pc_in = 32'h7F0;
      bus.rd_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_dout", bus.Dout, '0);
      chk("mid_rst_dvld", bus.Dout_valid, 1'b0);
      chk("mid_rst_hits", hit_count, 16'd0);
      chk("mid_rst_miss", miss_count, 16'd0);
      bus.rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      run_check("post_rst_a", 32'h7F0, 0);
      run_check("post_rst_b", 32'h40, 0);
      chk("post_rst_miss2", miss_count, 16'd2);

      // Counter saturation, starting each counter close to its ceiling
      @(negedge clk);
      force dut.hit_cnt_q = 16'hFFFC;
      @(posedge clk);
      #1;
      release dut.hit_cnt_q;
      m_hits = 32'hFFFC;
      chk("hit_preset", hit_count, 16'hFFFC);
      repeat (6) run_check("sat_hit", 32'h40, 0);
      chk("hit_sat", hit_count, 16'hFFFF);

      @(negedge clk);
      force dut.miss_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.miss_cnt_q;
      m_miss = 32'hFFFE;
      run_check("sat_miss_a", 32'h1040, 0);
      run_check("sat_miss_b", 32'h2040, 0);
      run_check("sat_miss_c", 32'h3040, 0);
      chk("miss_sat", miss_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
